// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu8bit among NREQ requesters.
// Optional ALU_ARB_OPCHECK_EN: illegal opcodes bypass the ALU and return rsp_err.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int ALU_LAT = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_opcode,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_out,
  output logic              rsp_cout,
  output logic              rsp_err,
  output logic              busy,
  output logic              alu_en,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_out,
  input  logic              alu_cout
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [IDW-1:0] last_reg, last_next;
  logic           busy_reg, busy_next;
  logic           alu_en_reg, alu_en_next;
  logic [3:0]     alu_opcode_reg, alu_opcode_next;
  logic [7:0]     alu_a_reg, alu_a_next;
  logic [7:0]     alu_b_reg, alu_b_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0] rsp_id_reg, rsp_id_next;
  logic [7:0]     rsp_out_reg, rsp_out_next;
  logic           rsp_cout_reg, rsp_cout_next;

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  rot_sel, win_id;
  logic [IDW:0]    win_sum;
  logic            win_found;
  logic [3:0]      sel_op;
  logic [7:0]      sel_a, sel_b;

  // Rotate valids so bit 0 is the requester after last_grant; lowest set bit wins.
  always_comb begin
    rot       = NREQ'({req_valid, req_valid} >> ({1'b0, last_reg} + (IDW+1)'(1)));
    win_found = 1'b0;
    rot_sel   = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        win_found = 1'b1;
        rot_sel   = IDW'(j);
      end
    end
    win_sum = {1'b0, last_reg} + (IDW+1)'(1) + {1'b0, rot_sel};
    if (win_sum >= (IDW+1)'(NREQ)) begin
      win_sum = win_sum - (IDW+1)'(NREQ);
    end
    win_id = win_sum[IDW-1:0];
    sel_op = req_opcode[4*win_id +: 4];
    sel_a  = req_a[8*win_id +: 8];
    sel_b  = req_b[8*win_id +: 8];
  end

  // Ready must coincide with the accepting edge, so it is decoded from the
  // registered state; gating with rst_n keeps it low while reset is held.
  assign req_ready = (state_reg == S_IDLE && rst_n && win_found) ?
                     (NREQ'(1) << win_id) : '0;

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_reg, rsp_err_next;
  logic sel_legal;
  assign sel_legal = sel_op inside {4'b1111, 4'b1110, 4'b0111, 4'b0110, 4'b0100};
`endif

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    last_next       = last_reg;
    alu_opcode_next = alu_opcode_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_out_next    = rsp_out_reg;
    rsp_cout_next   = rsp_cout_reg;
`ifdef ALU_ARB_OPCHECK_EN
    rsp_err_next    = rsp_err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (win_found) begin
          last_next       = win_id;
          state_next      = S_ISSUE;
          alu_opcode_next = sel_op;
          alu_a_next      = sel_a;
          alu_b_next      = sel_b;
`ifdef ALU_ARB_OPCHECK_EN
          if (!sel_legal) begin
            state_next      = S_DONE;
            alu_opcode_next = alu_opcode_reg;
            alu_a_next      = alu_a_reg;
            alu_b_next      = alu_b_reg;
            rsp_id_next     = win_id;
            rsp_out_next    = '0;
            rsp_cout_next   = 1'b0;
            rsp_err_next    = 1'b1;
          end
`endif
        end
      end
      S_ISSUE: begin
        state_next = S_WAIT;
        cnt_next   = CW'(ALU_LAT - 1);
      end
      S_WAIT: begin
        if (cnt_reg == '0) begin
          state_next    = S_DONE;
          rsp_id_next   = last_reg;
          rsp_out_next  = alu_out;
          rsp_cout_next = alu_cout;
`ifdef ALU_ARB_OPCHECK_EN
          rsp_err_next  = 1'b0;
`endif
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Registered outputs follow directly from the state being entered.
    busy_next      = (state_next != S_IDLE);
    alu_en_next    = (state_next == S_ISSUE) || (state_next == S_WAIT);
    rsp_valid_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      last_reg       <= IDW'(NREQ - 1);
      busy_reg       <= 1'b0;
      alu_en_reg     <= 1'b0;
      alu_opcode_reg <= '0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_out_reg    <= '0;
      rsp_cout_reg   <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_reg    <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      last_reg       <= last_next;
      busy_reg       <= busy_next;
      alu_en_reg     <= alu_en_next;
      alu_opcode_reg <= alu_opcode_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_out_reg    <= rsp_out_next;
      rsp_cout_reg   <= rsp_cout_next;
`ifdef ALU_ARB_OPCHECK_EN
      rsp_err_reg    <= rsp_err_next;
`endif
    end
  end

  assign busy       = busy_reg;
  assign alu_en     = alu_en_reg;
  assign alu_opcode = alu_opcode_reg;
  assign alu_a      = alu_a_reg;
  assign alu_b      = alu_b_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_out    = rsp_out_reg;
  assign rsp_cout   = rsp_cout_reg;
`ifdef ALU_ARB_OPCHECK_EN
  assign rsp_err    = rsp_err_reg;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural alu8bit model.
// Honours ALU_ARB_OPCHECK_EN the same way as the design.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int ALU_LAT = 2;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_opcode = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_out;
  logic              rsp_cout;
  logic              rsp_err;
  logic              busy;
  logic              alu_en;
  logic [3:0]        alu_opcode;
  logic [7:0]        alu_a;
  logic [7:0]        alu_b;
  logic [7:0]        alu_out;
  logic              alu_cout;

  alu_arbiter #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_out(rsp_out),
    .rsp_cout(rsp_cout), .rsp_err(rsp_err), .busy(busy), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'b1111: return {1'b0, a} + {1'b0, b};
      4'b1110: return {1'b0, a} - {1'b0, b};
      4'b0111: return {1'b0, a & b};
      4'b0110: return {1'b0, a | b};
      4'b0100: return {1'b0, ~a};
      default: return 9'h000;
    endcase
  endfunction

  // Garbage while disabled so a capture outside the enable window shows up.
  assign {alu_cout, alu_out} = alu_en ? alu_f(alu_opcode, alu_a, alu_b) : 9'h1A5;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     out;
    logic           cout;
    logic           err;
    int             due;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [NREQ-1:0] pend_v = '0;
  logic [3:0]      pend_op[NREQ];
  logic [7:0]      pend_a[NREQ];
  logic [7:0]      pend_b[NREQ];
  int              pend_rep[NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = pend_v[i];
      req_opcode[4*i +: 4] = pend_op[i];
      req_a[8*i +: 8]      = pend_a[i];
      req_b[8*i +: 8]      = pend_b[i];
    end
  endtask

  task automatic raise(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input int rep);
    pend_v[i]   = 1'b1;
    pend_op[i]  = op;
    pend_a[i]   = a;
    pend_b[i]   = b;
    pend_rep[i] = rep;
    drive_bus();
  endtask

  // Requester model + scoreboard: push on accept, pop on rsp_valid.
  initial begin : monitor
    exp_t e;
    int w;
    logic [8:0] r;
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk);
      acc = '0;
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_unexpected: got id=%0d out=%h, required no response", rsp_id, rsp_out);
        end else begin
          e = sb.pop_front();
          total++;
          if (rsp_id !== e.id) begin bad++; $display("FAIL rsp_id: got %0d, required %0d", rsp_id, e.id); end
          total++;
          if (rsp_out !== e.out) begin bad++; $display("FAIL rsp_out: got %h, required %h", rsp_out, e.out); end
          total++;
          if (rsp_cout !== e.cout) begin bad++; $display("FAIL rsp_cout: got %b, required %b", rsp_cout, e.cout); end
          total++;
          if (rsp_err !== e.err) begin bad++; $display("FAIL rsp_err: got %b, required %b", rsp_err, e.err); end
          total++;
          if (cyc != e.due) begin bad++; $display("FAIL rsp_latency: got cycle %0d, required cycle %0d", cyc, e.due); end
          $display("rsp id=%0d out=%h cout=%b err=%b cycle=%0d", rsp_id, rsp_out, rsp_cout, rsp_err, cyc);
        end
      end
      if (rst_n === 1'b1 && req_ready !== '0) begin
        total++;
        if ($countones(req_ready) != 1 || (req_ready & ~req_valid) != '0) begin
          bad++; $display("FAIL ready_onehot: got ready=%b, required one bit within valid=%b", req_ready, req_valid);
        end
        w = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) w = i;
        grant_log.push_back(w);
        r = alu_f(pend_op[w], pend_a[w], pend_b[w]);
        e.id = IDW'(w); e.out = r[7:0]; e.cout = r[8]; e.err = 1'b0; e.due = cyc + 2 + ALU_LAT;
`ifdef ALU_ARB_OPCHECK_EN
        if (!(pend_op[w] inside {4'b1111, 4'b1110, 4'b0111, 4'b0110, 4'b0100})) begin
          e.out = 8'h00; e.cout = 1'b0; e.err = 1'b1; e.due = cyc + 1;
        end
`endif
        sb.push_back(e);
        acc = req_ready;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          if (pend_rep[i] > 0) pend_rep[i]--;
          else pend_v[i] = 1'b0;
        end
      end
      drive_bus();
    end
  end

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && pend_v == '0) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s_timeout: got %0d outstanding, required 0", tag, sb.size()); end
  endtask

  task automatic test_reset();
    int exp_order[4] = '{0, 1, 2, 3};
    raise(0, 4'b1111, 8'h01, 8'h02, 0);
    raise(1, 4'b0110, 8'h0F, 8'hF0, 0);
    raise(2, 4'b0111, 8'h3C, 8'h0F, 0);
    raise(3, 4'b0100, 8'h0F, 8'h00, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b, required 0", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL reset_alu_en: got %b, required 0", alu_en); end
    total++; if ({alu_opcode, alu_a, alu_b} !== 20'h0) begin bad++; $display("FAIL reset_alu_bus: got %h, required 0", {alu_opcode, alu_a, alu_b}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
    total++; if ({rsp_id, rsp_out, rsp_cout, rsp_err} !== 12'h0) begin bad++; $display("FAIL reset_rsp_payload: got %h, required 0", {rsp_id, rsp_out, rsp_cout, rsp_err}); end
    @(posedge clk);
    #2;
    grant_log.delete();
    rst_n = 1'b1;
    wait_idle("reset");
    total++;
    if (grant_log.size() != 4) begin bad++; $display("FAIL reset_grants: got %0d grants, required 4", grant_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grant_log[i] != exp_order[i]) begin bad++; $display("FAIL reset_order[%0d]: got %0d, required %0d", i, grant_log[i], exp_order[i]); end
      end
    end
  endtask

  task automatic test_single_add();
    int n = 0;
    grant_log.delete();
    @(posedge clk); #2;
    raise(0, 4'b1111, 8'hFF, 8'hFF, 0);
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (alu_en === 1'b1) n++; end
    wait_idle("add");
    total++; if (n != ALU_LAT + 1) begin bad++; $display("FAIL add_alu_en_cycles: got %0d, required %0d", n, ALU_LAT + 1); end
    total++; if ({rsp_id, rsp_out, rsp_cout} !== {2'd0, 8'hFE, 1'b1}) begin bad++; $display("FAIL add_result: got id=%0d out=%h cout=%b, required id=0 out=fe cout=1", rsp_id, rsp_out, rsp_cout); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_strobe_width: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_contention();
    int exp_order[6] = '{1, 3, 1, 3, 1, 3};
    grant_log.delete();
    @(posedge clk); #2;
    raise(1, 4'b0110, 8'hCC, 8'h33, 2);
    raise(3, 4'b0111, 8'hCC, 8'h33, 2);
    wait_idle("contention");
    total++;
    if (grant_log.size() != 6) begin bad++; $display("FAIL contention_grants: got %0d grants, required 6", grant_log.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (grant_log[i] != exp_order[i]) begin bad++; $display("FAIL contention_order[%0d]: got %0d, required %0d", i, grant_log[i], exp_order[i]); end
      end
    end
    total++; if ({rsp_id, rsp_out} !== {2'd3, 8'h00}) begin bad++; $display("FAIL contention_last: got id=%0d out=%h, required id=3 out=00", rsp_id, rsp_out); end
  endtask

  task automatic test_subnot();
    @(posedge clk); #2;
    raise(2, 4'b1110, 8'h00, 8'h01, 0);
    wait_idle("sub");
    total++; if ({rsp_id, rsp_out, rsp_cout} !== {2'd2, 8'hFF, 1'b1}) begin bad++; $display("FAIL sub_result: got id=%0d out=%h cout=%b, required id=2 out=ff cout=1", rsp_id, rsp_out, rsp_cout); end
    raise(0, 4'b0100, 8'hAA, 8'h00, 0);
    wait_idle("not");
    total++; if ({rsp_id, rsp_out} !== {2'd0, 8'h55}) begin bad++; $display("FAIL not_result: got id=%0d out=%h, required id=0 out=55", rsp_id, rsp_out); end
  endtask

  task automatic test_midop_reset();
    bit got = 1'b0;
    grant_log.delete();
    @(posedge clk); #2;
    raise(1, 4'b1111, 8'h10, 8'h20, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (grant_log.size() > 0) begin got = 1'b1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL midop_accept_timeout: got no grant, required grant of 1"); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    total++; if ({alu_en, busy, rsp_valid} !== 3'b000) begin bad++; $display("FAIL midop_abort: got en/busy/valid=%b, required 000", {alu_en, busy, rsp_valid}); end
    repeat (6) @(posedge clk);
    #2;
    raise(1, 4'b1111, 8'h10, 8'h20, 0);
    wait_idle("midop_reissue");
    total++; if ({rsp_id, rsp_out} !== {2'd1, 8'h30}) begin bad++; $display("FAIL midop_reissue: got id=%0d out=%h, required id=1 out=30", rsp_id, rsp_out); end
  endtask

  task automatic test_illegal();
    int n = 0;
    @(posedge clk); #2;
    raise(2, 4'b0001, 8'h12, 8'h34, 0);
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (alu_en === 1'b1) n++; end
    wait_idle("illegal");
`ifdef ALU_ARB_OPCHECK_EN
    total++; if (n != 0) begin bad++; $display("FAIL illegal_alu_en: got %0d cycles, required 0", n); end
    total++; if ({rsp_id, rsp_err, rsp_out} !== {2'd2, 1'b1, 8'h00}) begin bad++; $display("FAIL illegal_rsp: got id=%0d err=%b out=%h, required id=2 err=1 out=00", rsp_id, rsp_err, rsp_out); end
`else
    total++; if (n != ALU_LAT + 1) begin bad++; $display("FAIL illegal_alu_en: got %0d cycles, required %0d", n, ALU_LAT + 1); end
    total++; if ({rsp_id, rsp_err} !== {2'd2, 1'b0}) begin bad++; $display("FAIL illegal_rsp: got id=%0d err=%b, required id=2 err=0", rsp_id, rsp_err); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[5] = '{4'b1111, 4'b1110, 4'b0111, 4'b0110, 4'b0100};
    int exp_order[8] = '{3, 0, 1, 2, 3, 0, 1, 2};
    int c0;
    grant_log.delete();
    @(posedge clk); #2;
    c0 = cyc;
    for (int i = 0; i < NREQ; i++) begin
      raise(i, ops[$urandom_range(0, 4)], 8'($urandom), 8'($urandom), 1);
    end
    wait_idle("b2b");
    total++; if (cyc != c0 + 8 * (ALU_LAT + 3)) begin bad++; $display("FAIL b2b_throughput: got %0d cycles, required %0d", cyc - c0, 8 * (ALU_LAT + 3)); end
    total++;
    if (grant_log.size() != 8) begin bad++; $display("FAIL b2b_grants: got %0d grants, required 8", grant_log.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (grant_log[i] != exp_order[i]) begin bad++; $display("FAIL b2b_order[%0d]: got %0d, required %0d", i, grant_log[i], exp_order[i]); end
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    for (int i = 0; i < NREQ; i++) begin
      pend_op[i] = '0; pend_a[i] = '0; pend_b[i] = '0; pend_rep[i] = 0;
    end
    test_reset();
    test_single_add();
    test_contention();
    test_subnot();
    test_midop_reset();
    test_illegal();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
